// File: rtl/adc_seq_pkg.sv
// Shared types and width helpers for the ADC burst sequencer.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4
  } seq_state_t;

  localparam logic SRC_PERIODIC = 1'b0;
  localparam logic SRC_SOFTWARE = 1'b1;

  // Accumulator width: one conversion word plus headroom for the whole burst.
  function automatic int sum_width(input int data_w, input int burst_len_log2);
    return data_w + burst_len_log2;
  endfunction

endpackage

// File: rtl/adc_sample_sequencer_if.sv
// Conversion and result handshake bundle between the sequencer and its neighbours.
// ADC_SEQ_MINMAX_EN adds per-burst min/max words to the result side.
interface adc_sample_sequencer_if #(
  parameter int DATA_W = 12
);
  logic              conv_start;
  logic              conv_done;
  logic [DATA_W-1:0] pdata1;
  logic [DATA_W-1:0] pdata2;
  logic [DATA_W-1:0] avg1;
  logic [DATA_W-1:0] avg2;
  logic              burst_src;
  logic              result_valid;
  logic              result_ready;
`ifdef ADC_SEQ_MINMAX_EN
  logic [DATA_W-1:0] min1;
  logic [DATA_W-1:0] max1;
  logic [DATA_W-1:0] min2;
  logic [DATA_W-1:0] max2;

  modport master (
    output conv_start, avg1, avg2, burst_src, result_valid, min1, max1, min2, max2,
    input  conv_done, pdata1, pdata2, result_ready
  );
  modport slave (
    input  conv_start, avg1, avg2, burst_src, result_valid, min1, max1, min2, max2,
    output conv_done, pdata1, pdata2, result_ready
  );
`else
  modport master (
    output conv_start, avg1, avg2, burst_src, result_valid,
    input  conv_done, pdata1, pdata2, result_ready
  );
  modport slave (
    input  conv_start, avg1, avg2, burst_src, result_valid,
    output conv_done, pdata1, pdata2, result_ready
  );
`endif
endinterface

// File: rtl/adc_seq_period_timer.sv
// Enable-gated modulo-PERIOD_CYCLES counter; tick pulses for one cycle after each terminal count.
module adc_seq_period_timer #(
  parameter int PERIOD_CYCLES = 20000
) (
  input  logic clk_20M,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);
  localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;

  // Free-running period counter, parked at zero while disabled.
  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (!enable) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + 1'b1;
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;
endmodule

// File: rtl/adc_sample_sequencer.sv
// Burst sequencer: arbitrates periodic/software requests and averages 2^BURST_LEN_LOG2 conversions.
// Define ADC_SEQ_MINMAX_EN to also report per-burst channel min/max.
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int DATA_W         = 12,
  parameter int BURST_LEN_LOG2 = 7,
  parameter int PERIOD_CYCLES  = 20000,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_20M,
  input  logic reset_n,
  input  logic enable,
  input  logic sw_trig,
  input  logic err_clr,
  output logic busy,
  output logic err_timeout,
  output logic err_overrun,
  adc_sample_sequencer_if.master bus
);
  localparam int SUM_W = sum_width(DATA_W, BURST_LEN_LOG2);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [BURST_LEN_LOG2-1:0] LAST_SAMPLE = {BURST_LEN_LOG2{1'b1}};
  // Expiry one count early so the error is visible exactly TIMEOUT_CYCLES after conv_start.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

  seq_state_t              state_r;
  logic [SUM_W-1:0]        sum1_r, sum2_r;
  logic [BURST_LEN_LOG2-1:0] sample_cnt_r;
  logic [TMO_W-1:0]        tmo_cnt_r;
  logic [DATA_W-1:0]       avg1_r, avg2_r;
  logic                    src_r, conv_start_r, result_valid_r, busy_r;
  logic                    pend_sw_r, pend_per_r, err_timeout_r, err_overrun_r;
  logic                    tick_s, grant_s, grant_sw_s, grant_per_s, ovr_evt_s, tmo_evt_s;
`ifdef ADC_SEQ_MINMAX_EN
  logic [DATA_W-1:0]       run_min1_r, run_max1_r, run_min2_r, run_max2_r;
  logic [DATA_W-1:0]       min1_r, max1_r, min2_r, max2_r;
`endif

  adc_seq_period_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_timer (
    .clk_20M (clk_20M),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (tick_s)
  );

  // Grant arbitration (software first) and error event detection.
  always_comb begin
    grant_s     = (state_r == IDLE) && enable && (pend_sw_r || pend_per_r);
    grant_sw_s  = grant_s && pend_sw_r;
    grant_per_s = grant_s && !pend_sw_r;
    ovr_evt_s   = enable && ((sw_trig && pend_sw_r && !grant_sw_s) ||
                             (tick_s && pend_per_r && !grant_per_s));
    tmo_evt_s   = (state_r == WAIT) && !bus.conv_done && (tmo_cnt_r == TMO_LAST);
  end

  // One-deep pending flags per source plus sticky errors; a new event beats err_clr.
  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      pend_sw_r     <= 1'b0;
      pend_per_r    <= 1'b0;
      err_timeout_r <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      if (!enable) begin
        pend_sw_r  <= 1'b0;
        pend_per_r <= 1'b0;
      end else begin
        pend_sw_r  <= (pend_sw_r && !grant_sw_s) || sw_trig;
        pend_per_r <= (pend_per_r && !grant_per_s) || tick_s;
      end
      err_timeout_r <= tmo_evt_s || (err_timeout_r && !err_clr);
      err_overrun_r <= ovr_evt_s || (err_overrun_r && !err_clr);
    end
  end

  // Burst FSM with registered handshake outputs.
  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      sum1_r         <= '0;
      sum2_r         <= '0;
      sample_cnt_r   <= '0;
      tmo_cnt_r      <= '0;
      avg1_r         <= '0;
      avg2_r         <= '0;
      src_r          <= SRC_PERIODIC;
      conv_start_r   <= 1'b0;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
`ifdef ADC_SEQ_MINMAX_EN
      run_min1_r <= '1; run_max1_r <= '0; run_min2_r <= '1; run_max2_r <= '0;
      min1_r     <= '1; max1_r     <= '0; min2_r     <= '1; max2_r     <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          result_valid_r <= 1'b0;
          if (grant_s) begin
            state_r      <= START;
            src_r        <= pend_sw_r ? SRC_SOFTWARE : SRC_PERIODIC;
            sum1_r       <= '0;
            sum2_r       <= '0;
            sample_cnt_r <= '0;
            conv_start_r <= 1'b1;
            busy_r       <= 1'b1;
`ifdef ADC_SEQ_MINMAX_EN
            run_min1_r <= '1; run_max1_r <= '0; run_min2_r <= '1; run_max2_r <= '0;
`endif
          end else begin
            conv_start_r <= 1'b0;
            busy_r       <= 1'b0;
          end
        end
        START: begin
          conv_start_r <= 1'b0;
          tmo_cnt_r    <= '0;
          state_r      <= WAIT;
        end
        WAIT: begin
          if (bus.conv_done) begin
            sum1_r <= sum1_r + SUM_W'(bus.pdata1);
            sum2_r <= sum2_r + SUM_W'(bus.pdata2);
`ifdef ADC_SEQ_MINMAX_EN
            if (bus.pdata1 < run_min1_r) run_min1_r <= bus.pdata1;
            if (bus.pdata1 > run_max1_r) run_max1_r <= bus.pdata1;
            if (bus.pdata2 < run_min2_r) run_min2_r <= bus.pdata2;
            if (bus.pdata2 > run_max2_r) run_max2_r <= bus.pdata2;
`endif
            if (sample_cnt_r == LAST_SAMPLE) begin
              state_r <= DONE;
            end else begin
              sample_cnt_r <= sample_cnt_r + 1'b1;
              conv_start_r <= 1'b1;
              state_r      <= START;
            end
          end else if (tmo_evt_s) begin
            sum1_r  <= '0;
            sum2_r  <= '0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
          end
        end
        DONE: begin
          avg1_r         <= DATA_W'(sum1_r >> BURST_LEN_LOG2);
          avg2_r         <= DATA_W'(sum2_r >> BURST_LEN_LOG2);
          result_valid_r <= 1'b1;
          state_r        <= HOLD;
`ifdef ADC_SEQ_MINMAX_EN
          min1_r <= run_min1_r; max1_r <= run_max1_r;
          min2_r <= run_min2_r; max2_r <= run_max2_r;
`endif
        end
        HOLD: begin
          if (bus.result_ready) begin
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            state_r        <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r        <= IDLE;
          conv_start_r   <= 1'b0;
          result_valid_r <= 1'b0;
          busy_r         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.conv_start   = conv_start_r;
  assign bus.avg1         = avg1_r;
  assign bus.avg2         = avg2_r;
  assign bus.burst_src    = src_r;
  assign bus.result_valid = result_valid_r;
  assign busy             = busy_r;
  assign err_timeout      = err_timeout_r;
  assign err_overrun      = err_overrun_r;
`ifdef ADC_SEQ_MINMAX_EN
  assign bus.min1 = min1_r;
  assign bus.max1 = max1_r;
  assign bus.min2 = min2_r;
  assign bus.max2 = max2_r;
`endif
endmodule

// File: doc/adc_sample_sequencer.md
Name: adc_sample_sequencer

Overview:
Burst-level controller above the dual-channel serial ADC front end. It arbitrates between two acquisition requesters: an internal periodic timer and a software trigger. For each granted request it issues 2^BURST_LEN_LOG2 single-conversion starts and accumulates both 12-bit channel words. It then presents the averaged pair on a valid/ready handshake to the force-processing logic, and flags conversion timeouts and trigger overruns.

Parameters:
DATA_W, 12, ADC word width per channel
BURST_LEN_LOG2, 7, log2 conversions per burst (128)
PERIOD_CYCLES, 20000, clk_20M cycles between periodic triggers (1 kHz)
TIMEOUT_CYCLES, 64, max cycles from conv_start to conv_done

Ports:
clk_20M  in  1  system clock, 20 MHz
reset_n  in  1  asynchronous reset, active low
enable  in  1  sequencer enable; gates periodic timer and new bursts
sw_trig  in  1  software burst request, single-cycle pulse
err_clr  in  1  clears sticky error flags
conv_start  out  1  one-cycle pulse: start one dual-channel conversion
conv_done  in  1  one-cycle pulse: pdata1/pdata2 valid this cycle
pdata1  in  DATA_W  channel 1 conversion word
pdata2  in  DATA_W  channel 2 conversion word
avg1  out  DATA_W  channel 1 burst average
avg2  out  DATA_W  channel 2 burst average
burst_src  out  1  source of the presented result: 0 periodic, 1 software
result_valid  out  1  averaged result available
result_ready  in  1  consumer accepts result
busy  out  1  burst in progress or result held
err_timeout  out  1  sticky: conv_done missed
err_overrun  out  1  sticky: trigger arrived while same-source request already pending

Behaviour:
- Reset (reset_n low, async): state IDLE; all outputs 0; accumulators, counters, pending flags and timer cleared.
- Timer: counts 0..PERIOD_CYCLES-1 while enable=1. Terminal count sets pend_per. Timer is held at 0 while enable=0.
- sw_trig sets pend_sw; sw_trig is ignored while enable=0.
- A trigger whose pending flag is already set sets err_overrun. Pending depth is one per source.
- IDLE: if enable and any pending flag, grant and go to START. Software has priority. Clear the granted flag, latch burst_src, zero the sums and the sample counter.
- START: conv_start=1 for exactly one cycle; go to WAIT and clear the timeout counter.
- WAIT:
  - conv_done: add pdata1/pdata2 into sum1/sum2, each DATA_W+BURST_LEN_LOG2 bits, unsigned, no saturation needed.
  - If the sample counter equals 2^BURST_LEN_LOG2-1, go to DONE; else increment the counter and go to START.
  - No conv_done within TIMEOUT_CYCLES: set err_timeout, discard the sums, go to IDLE, no result.
  - conv_done outside WAIT is ignored.
- DONE (1 cycle): avg = sum >> BURST_LEN_LOG2, truncating. Register avg1/avg2; go to HOLD.
- HOLD: result_valid=1; avg/burst_src stable. When result_valid&result_ready, go to IDLE; result_valid drops the next cycle.
- Latency: the first conv_start occurs 2 cycles after a trigger pulse when IDLE. result_valid rises 2 cycles after the final conv_done.
- busy=1 in every state except IDLE.
- enable deasserted mid-burst: the burst and hold complete normally. Pending flags clear and no new burst starts.
- Simultaneous timer terminal count and sw_trig: both flags set, software served first.
- err_clr: clears both sticky flags. If err_clr coincides with a new error event, the error wins.

Optional Feature:
ADC_SEQ_MINMAX_EN:
- Defined: adds outputs min1, max1, min2, max2 (DATA_W each). They track per-burst extrema, are reset with the sums at burst grant, are registered in DONE, and are valid alongside result_valid. Reset value of min is all-ones and of max is 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package adc_seq_pkg: state enum (IDLE, START, WAIT, DONE, HOLD), burst_src encodings, and a SUM_W derivation constant/function.
- Sub-module adc_seq_period_timer: enable-gated modulo-PERIOD_CYCLES counter with a terminal-count pulse output.

Test Plan:
- Constant pdata1=12'hABC, pdata2=12'h123 with a conv_done responder 5 cycles after each conv_start; sw_trig -> 128 conv_start pulses, then avg1=12'hABC, avg2=12'h123, burst_src=1.
- Ramp pdata1=0..127, PERIOD_CYCLES=300, BURST_LEN_LOG2=2 -> avg1 values (0+1+2+3)>>2=1, then 5, 9, and so on; burst_src=0.
- result_ready held low 1000 cycles -> result_valid and avg stable. A second timer tick sets pend_per; a third tick sets err_overrun=1; err_clr clears it.
- Responder suppresses conv_done on conversion 10 -> err_timeout=1 exactly TIMEOUT_CYCLES after that conv_start, no result_valid, state IDLE.
- Timer tick and sw_trig in the same cycle -> software burst first, periodic burst immediately after HOLD release.
- reset_n pulsed low mid-WAIT -> all outputs 0 asynchronously; a clean burst completes after release.
